// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrate, capture, execute, hold response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state;
    logic [3:0]      cap_op;
    logic [XLEN-1:0] cap_a;
    logic [XLEN-1:0] cap_b;
    logic            cap_id;
    logic            grant_any;
    logic            grant_id;
    logic            op_undef;

    // Readies are gated by rst_n so every output reads 0 while reset is held.
    assign grant_any = rst_n && (state == IDLE) && (req0_valid || req1_valid);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant_id = !req0_valid;
`else
    logic last_id;

    always_comb begin
        grant_id = !req0_valid;
        if (req0_valid && req1_valid)
            grant_id = !last_id;
    end

    // Reset value 1 means the first contested grant goes to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_id <= 1'b1;
        else if (grant_any)
            last_id <= grant_id;
    end
`endif

    assign req0_ready = grant_any && !grant_id;
    assign req1_ready = grant_any && grant_id;

    assign alu_a    = cap_a;
    assign alu_b    = cap_b;
    assign alu_ctrl = cap_op;
    assign op_undef = (cap_op > 4'd12);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_op     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cap_id <= grant_id;
                        cap_op <= grant_id ? req1_op : req0_op;
                        cap_a  <= grant_id ? req1_a  : req0_a;
                        cap_b  <= grant_id ? req1_b  : req0_b;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= cap_id;
                    rsp_err    <= op_undef;
                    rsp_result <= op_undef ? '0 : alu_result;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model checked every cycle plus directed literals.
module tb_alu_arbiter;

    localparam int XLEN = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [3:0]      req0_op = '0, req1_op = '0;
    logic [XLEN-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_ctrl;
    logic            rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
    logic [XLEN-1:0] rsp_result;

    int n_pass = 0;
    int n_total = 0;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Shared ALU; undefined codes return junk so the arbiter's zero-forcing is visible.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return {31'd0, a == b};
            4'd9:  return {31'd0, a < b};
            4'd10: return {31'd0, a >= b};
            4'd11: return {31'd0, $signed(a) < $signed(b)};
            4'd12: return {31'd0, $signed(a) >= $signed(b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: at most one operation in flight; age counts cycles since acceptance.
    bit          m_busy = 1'b0;
    int          m_age = 0;
    bit          m_last = 1'b1;
    bit          m_id;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;

    always @(negedge clk) begin
        int w;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            check("rst_rsp", {29'd0, rsp_valid, rsp_id, rsp_err}, 32'd0);
            check("rst_result", rsp_result, 32'd0);
            check("rst_alu", alu_a | alu_b | {28'd0, alu_ctrl}, 32'd0);
        end else if (!m_busy) begin
            w = -1;
            if (req0_valid && req1_valid) w = FIXED ? 0 : (m_last ? 0 : 1);
            else if (req0_valid) w = 0;
            else if (req1_valid) w = 1;
            check("idle_ready0", {31'd0, req0_ready}, {31'd0, w == 0});
            check("idle_ready1", {31'd0, req1_ready}, {31'd0, w == 1});
            check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            if (w >= 0) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = (w == 1);
                m_op   = m_id ? req1_op : req0_op;
                m_a    = m_id ? req1_a : req0_a;
                m_b    = m_id ? req1_b : req0_b;
                m_last = m_id;
            end
        end else begin
            m_age++;
            check("busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            if (m_age == 1) begin
                check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
                check("exec_alu_a", alu_a, m_a);
                check("exec_alu_b", alu_b, m_b);
                check("exec_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_op});
            end else begin
                check("resp_valid", {31'd0, rsp_valid}, 32'd1);
                check("resp_id", {31'd0, rsp_id}, {31'd0, m_id});
                check("resp_err", {31'd0, rsp_err}, {31'd0, m_op > 4'd12});
                check("resp_result", rsp_result, (m_op > 4'd12) ? 32'd0 : alu_fn(m_op, m_a, m_b));
                if (rsp_ready) m_busy = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        repeat (4) tick();
    endtask

    // Waits (bounded) for rsp_valid at a negedge; returns 0 on timeout.
    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int ngrant;
        int grants[4];
        logic [31:0] held;

        // Reset with both requesters valid: nothing may be granted.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("lit_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single ADD 5+7 from requester 0.
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        check("lit_add_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("lit_add_exec_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("lit_add_valid", {31'd0, rsp_valid}, 32'd1);
        check("lit_add_result", rsp_result, 32'd12);
        check("lit_add_id_err", {30'd0, rsp_id, rsp_err}, 32'd0);
        drain();

        // Both valid every slot after reset: grants 0,1,0,1 (all 0 with fixed priority).
        do_reset();
        req0_op = 4'd1;  req0_a = 32'd10;         req0_b = 32'd3;
        req1_op = 4'd11; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        ngrant = 0;
        for (int i = 0; i < 20 && ngrant < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) check("lit_rr_result", rsp_result, rsp_id ? 32'd1 : 32'd7);
            if (req0_ready || req1_ready) begin
                grants[ngrant] = req1_ready ? 1 : 0;
                ngrant++;
            end
        end
        check("lit_rr_count", ngrant, 4);
        for (int i = 0; i < 4; i++)
            check("lit_rr_grant", grants[i], FIXED ? 0 : i % 2);
        drain();

        // Backpressure: response held stable for 5 cycles, no grants while waiting.
        rsp_ready = 1'b0;
        req1_op = 4'd4; req1_a = 32'hA5A5_0F0F; req1_b = 32'h0FF0_FFFF;
        req1_valid = 1'b1;
        tick();
        req0_valid = 1'b1;
        wait_rsp(ok);
        held = rsp_result;
        check("lit_bp_result", held, 32'hAA55_F0F0);
        repeat (5) begin
            @(negedge clk);
            check("lit_bp_stable", rsp_result, held);
            check("lit_bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();

        // Undefined op 14 forces a zero result with the error flag.
        req0_valid = 1'b1; req0_op = 4'd14; req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF;
        tick();
        req0_valid = 1'b0;
        wait_rsp(ok);
        check("lit_err_flag", {31'd0, rsp_err}, 32'd1);
        check("lit_err_result", rsp_result, 32'd0);
        drain();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = 4'($urandom_range(0, 15));
            req1_op = 4'($urandom_range(0, 15));
            req0_a = $urandom;
            req1_a = $urandom;
            req0_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            req1_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset during EXEC: operation discarded, pointer back to requester 0.
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = req0_ready;
        end
        check("lit_rst_accept", {31'd0, ok}, 32'd1);
        tick();
        req0_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("lit_rst_exec_rsp", {29'd0, rsp_valid, rsp_id, rsp_err}, 32'd0);
        check("lit_rst_exec_alu", alu_a | alu_b | rsp_result, 32'd0);
        repeat (2) @(negedge clk);
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("lit_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        tick();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("lit_rst_grant", {30'd0, req0_ready, req1_ready}, 32'd2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; fixed at 32 to match the shared ALU.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_op / req1_op  in  4  ALU control code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 EQ, 9 ULT, 10 UGTE, 11 SLT, 12 SGTE.
REQ-007 req0_a, req0_b / req1_a, req1_b  in  32  operands.
REQ-008 alu_a, alu_b  out  32  operands driven to the shared ALU.
REQ-009 alu_ctrl  out  4  control code driven to the shared ALU.
REQ-010 alu_result  in  32  combinational result from the shared ALU.
REQ-011 rsp_valid  out  1  response held for the consumer.
REQ-012 rsp_ready  in  1  consumer accepts the response.
REQ-013 rsp_id  out  1  requester that owns the response.
REQ-014 rsp_result  out  32  registered ALU result.
REQ-015 rsp_err  out  1  op code was 13-15 (undefined).

Function
REQ-016 FSM states: IDLE, EXEC, RESP.
REQ-017 IDLE: if any reqN_valid, assert the winner's reqN_ready combinationally in that cycle, capture its op/a/b/id, and go to EXEC; otherwise stay in IDLE.
REQ-018 The loser's ready stays 0; both readies are 0 outside IDLE.
REQ-019 Round-robin: when both are valid, grant the requester not granted last; a lone valid requester always wins.
REQ-020 alu_a/alu_b/alu_ctrl are driven only from the capture registers, never from request inputs.
REQ-021 EXEC (one cycle): register alu_result into rsp_result, set rsp_err = (op > 12), and go to RESP.
REQ-022 rsp_err=1 forces rsp_result to 0, regardless of alu_result.
REQ-023 RESP: hold rsp_valid=1 and all rsp_* outputs stable until rsp_ready=1, then go to IDLE and drop rsp_valid on the next edge.
REQ-024 Latency: accept at edge N gives rsp_valid=1 in cycle N+2; minimum issue interval is 3 cycles.
REQ-025 No new request is accepted in the cycle rsp_ready completes a response.
REQ-026 A requester deasserting valid without ready has no effect and leaves the arbitration pointer unchanged.

Reset
REQ-027 rst_n low, asynchronously: state=IDLE, and all outputs and capture registers are 0.
REQ-028 After reset the pointer favours requester 0.
REQ-029 Reset in EXEC or RESP discards the in-flight operation; no response is produced.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins simultaneous requests, and the pointer logic is removed.
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Verification
REQ-032 Single request: req0 ADD a=5 b=7 -> ready 1 cycle, rsp_valid 2 cycles later with result=12, id=0, err=0.
REQ-033 Both valid every slot, ops SUB 10-3 and SLT -1<1 -> grants alternate 0,1,0,1 with results 7 / 1; with ALU_ARB_FIXED_PRIO_EN, always id=0.
REQ-034 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, no req_ready asserted, completes after ready.
REQ-035 Op=14, a=b=0xFFFFFFFF -> rsp_err=1, rsp_result=0.
REQ-036 rst_n pulse during EXEC -> no rsp_valid, all outputs 0; next simultaneous request is granted to requester 0.
